serial_tx_arbiter: RTL and testbench

- Shares one quick_rs232 transmitter between NUM_REQ byte producers using round-robin arbitration with bounded bursts.
- Sequences the transmitter's tx_transaction / tx_data_ready / tx_data_copied / tx_busy handshake on behalf of the granted requester.
- Sits between application logic (echo path, status reporters, debug dumpers) and the quick_rs232 instance, replacing ad-hoc per-design TX state machines.

---
 rtl/serial_pkg.sv | 43 ++++
 rtl/serial_tx_arbiter_if.sv | 37 +++
 rtl/rr_pick.sv | 39 +++
 rtl/serial_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared state encoding and default timing for the serial TX
//                arbiter and its helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SETUP     = 3'd1;
   localparam logic [2:0] ST_WAIT_FREE = 3'd2;
   localparam logic [2:0] ST_LOAD      = 3'd3;
   localparam logic [2:0] ST_NEXT      = 3'd4;
   localparam logic [2:0] ST_CLOSE     = 3'd5;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      SETUP     = ST_SETUP,
      WAIT_FREE = ST_WAIT_FREE,
      LOAD      = ST_LOAD,
      NEXT      = ST_NEXT,
      CLOSE     = ST_CLOSE
   } state_t;

   localparam int DEF_SETUP_CYCLES = 10;
   localparam int DEF_HOLD_CYCLES  = 10;
   localparam int DEF_COPY_TIMEOUT = 255;
   localparam int DEF_MAX_BURST    = 4;

   // Bit width able to hold 0..v-1, never narrower than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_arbiter_if
//  Description : Requester-side and quick_rs232-side signals of the TX arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ack;
   logic [NUM_REQ-1:0]            grant;
   logic                          tx_transaction;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_data_ready;
   logic                          tx_data_copied;
   logic                          tx_busy;
   logic                          arb_busy;
   logic                          err_timeout;

   // Arbiter side
   modport master (
      input  req_valid, req_data, tx_data_copied, tx_busy,
      output req_ack, grant, tx_transaction, tx_data, tx_data_ready,
             arb_busy, err_timeout
   );

   // Requesters plus transmitter side
   modport slave (
      output req_valid, req_data, tx_data_copied, tx_busy,
      input  req_ack, grant, tx_transaction, tx_data, tx_data_ready,
             arb_busy, err_timeout
   );
endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector: first valid index at or
//                above the pointer, wrapping past NUM_REQ-1.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  wire logic [NUM_REQ-1:0] i_valid,
   input  wire logic [IDX_W-1:0]   i_ptr,
   output logic      [IDX_W-1:0]   o_idx,
   output logic                    o_found
);
   int               w_pos;
   logic [IDX_W-1:0] w_cand;

   // Scan from the farthest offset down so the nearest valid entry wins last.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      w_pos   = 0;
      w_cand  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
         end
         w_cand = w_pos[IDX_W-1:0];
         if (i_valid[w_cand]) begin
            o_idx   = w_cand;
            o_found = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_arbiter
//  Description : Round-robin, burst-limited sharing of one quick_rs232
//                transmitter between NUM_REQ byte producers.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_tx_arbiter
   import serial_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int SETUP_CYCLES = serial_pkg::DEF_SETUP_CYCLES,
   parameter int HOLD_CYCLES  = serial_pkg::DEF_HOLD_CYCLES,
   parameter int MAX_BURST    = serial_pkg::DEF_MAX_BURST,
   parameter int COPY_TIMEOUT = serial_pkg::DEF_COPY_TIMEOUT
) (
   input wire logic            clk,
   input wire logic            rst,
   serial_tx_arbiter_if.master bus
);
   localparam int IDX_W   = clog2_min1(NUM_REQ);
   localparam int CNT_W   = clog2_min1(max3(SETUP_CYCLES, HOLD_CYCLES, COPY_TIMEOUT));
   localparam int BURST_W = clog2_min1(MAX_BURST + 1);

   localparam logic [CNT_W-1:0]   C_SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0]   C_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   C_TIMEOUT_LAST = CNT_W'(COPY_TIMEOUT - 1);
   localparam logic [BURST_W-1:0] C_MAX_BURST    = BURST_W'(MAX_BURST);
   localparam logic [IDX_W-1:0]   C_LAST_IDX     = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] C_ONE          = NUM_REQ'(1);

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [BURST_W-1:0]    r_burst;
   logic [IDX_W-1:0]      r_ptr;
   logic [IDX_W-1:0]      r_gidx;
   logic [NUM_REQ-1:0]    r_grant;
   logic [NUM_REQ-1:0]    r_ack;
   logic                  r_tx_transaction;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_tx_data_ready;
   logic                  r_arb_busy;
   logic                  r_err_timeout;

   logic [IDX_W-1:0]      w_pick_idx;
   logic                  w_pick_found;
   logic [IDX_W-1:0]      w_next_ptr;
   logic                  w_req_valid_g;
   logic [DATA_WIDTH-1:0] w_req_byte;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_valid (bus.req_valid),
      .i_ptr   (r_ptr),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   assign w_next_ptr    = (r_gidx == C_LAST_IDX) ? '0 : r_gidx + 1'b1;
   assign w_req_valid_g = bus.req_valid[r_gidx];
   assign w_req_byte    = bus.req_data[int'(r_gidx) * DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= IDLE;
         r_cnt            <= '0;
         r_burst          <= '0;
         r_ptr            <= '0;
         r_gidx           <= '0;
         r_grant          <= '0;
         r_ack            <= '0;
         r_tx_transaction <= 1'b0;
         r_tx_data        <= '0;
         r_tx_data_ready  <= 1'b0;
         r_arb_busy       <= 1'b0;
         r_err_timeout    <= 1'b0;
      end else begin
         r_ack         <= '0;
         r_err_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_found) begin
                  r_gidx           <= w_pick_idx;
                  r_grant          <= C_ONE << w_pick_idx;
                  r_tx_transaction <= 1'b1;
                  r_arb_busy       <= 1'b1;
                  r_cnt            <= '0;
                  r_burst          <= '0;
                  r_state          <= SETUP;
               end
            end
            SETUP: begin
               if (r_cnt == C_SETUP_LAST) begin
                  r_cnt   <= '0;
                  r_state <= WAIT_FREE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_FREE: begin
               if (!w_req_valid_g) begin
                  r_cnt   <= '0;
                  r_state <= CLOSE;
               end else if (!bus.tx_busy) begin
                  r_tx_data       <= w_req_byte;
                  r_tx_data_ready <= 1'b1;
                  r_cnt           <= '0;
                  r_state         <= LOAD;
               end
            end
            LOAD: begin
               // A copy arriving on the timeout cycle still counts as delivered.
               if (bus.tx_data_copied) begin
                  r_tx_data_ready <= 1'b0;
                  r_ack           <= r_grant;
                  r_burst         <= r_burst + 1'b1;
                  r_state         <= NEXT;
               end else if (r_cnt == C_TIMEOUT_LAST) begin
                  r_tx_data_ready <= 1'b0;
                  r_err_timeout   <= 1'b1;
                  r_cnt           <= '0;
                  r_state         <= CLOSE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            NEXT: begin
               if (r_burst == C_MAX_BURST) begin
                  r_cnt   <= '0;
                  r_state <= CLOSE;
               end else begin
                  r_state <= WAIT_FREE;
               end
            end
            CLOSE: begin
               // Hold time restarts while the transmitter is still shifting.
               if (bus.tx_busy) begin
                  r_cnt <= '0;
               end else if (r_cnt == C_HOLD_LAST) begin
                  r_tx_transaction <= 1'b0;
                  r_grant          <= '0;
                  r_ptr            <= w_next_ptr;
                  r_arb_busy       <= 1'b0;
                  r_cnt            <= '0;
                  r_state          <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ack        = r_ack;
   assign bus.grant          = r_grant;
   assign bus.tx_transaction = r_tx_transaction;
   assign bus.tx_data        = r_tx_data;
   assign bus.tx_data_ready  = r_tx_data_ready;
   assign bus.arb_busy       = r_arb_busy;
   assign bus.err_timeout    = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_arbiter
//  Description : Self-checking bench for serial_tx_arbiter with a stub
//                quick_rs232 and a queue-based round-robin reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_tx_arbiter;
   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int SETUP = 10;
   localparam int HOLD  = 10;
   localparam int MAXB  = 4;
   localparam int TMO   = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

   serial_tx_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .SETUP_CYCLES(SETUP),
      .HOLD_CYCLES(HOLD), .MAX_BURST(MAXB), .COPY_TIMEOUT(TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int            g;
      logic [DW-1:0] d;
   } xfer_t;

   typedef struct {
      logic [N-1:0]      mask;
      int                n;
      logic [3:0][2:0]   order;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   int            ack_cnt [N];
   int            err_cnt;
   logic [DW-1:0] rq [N][$];
   xfer_t         log_q[$];
   xfer_t         exp_q[$];
   int            copy_dly, busy_len, busy_left, wait_cnt;
   bit            copy_never, force_busy;
   int            model_ptr;
   vec_t          tbl [6];

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic vec_t mkvec(input logic [N-1:0] m, input int n,
                                  input int o0, input int o1, input int o2, input int o3);
      vec_t v;
      v.mask = m;
      v.n = n;
      v.order[0] = 3'(o0);
      v.order[1] = 3'(o1);
      v.order[2] = 3'(o2);
      v.order[3] = 3'(o3);
      return v;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_req();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]         = (rq[i].size() > 0);
         bus.req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : '0;
      end
   endtask

   // One clock: observe DUT on the falling edge, then play requesters and transmitter.
   task automatic step();
      xfer_t x;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (bus.req_ack[i]) begin
            ack_cnt[i]++;
            if (rq[i].size() > 0) void'(rq[i].pop_front());
         end
      end
      if (bus.err_timeout) err_cnt++;
      bus.tx_data_copied = 1'b0;
      if (busy_left > 0) busy_left--;
      if (bus.tx_data_ready && !copy_never) begin
         if (wait_cnt >= copy_dly) begin
            bus.tx_data_copied = 1'b1;
            x.g = onehot_idx(bus.grant);
            x.d = bus.tx_data;
            log_q.push_back(x);
            busy_left = busy_len;
            wait_cnt  = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
      bus.tx_busy = force_busy || (busy_left > 0);
      drive_req();
   endtask

   // Reference: serve queues round-robin from the pointer, up to MAXB bytes per turn.
   task automatic build_expect();
      logic [DW-1:0] m [N][$];
      xfer_t x;
      int p, g, sent;
      for (int i = 0; i < N; i++) m[i] = rq[i];
      p = model_ptr;
      exp_q.delete();
      while (1) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && m[(p + k) % N].size() > 0) g = (p + k) % N;
         end
         if (g < 0) break;
         sent = 0;
         while (m[g].size() > 0 && sent < MAXB) begin
            x.g = g;
            x.d = m[g].pop_front();
            exp_q.push_back(x);
            sent++;
         end
         p = (g + 1) % N;
      end
      model_ptr = p;
   endtask

   task automatic run_drain(input string name, input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(all_empty() && !bus.arb_busy) && n < budget);
      check({name, "_drain"}, int'(n < budget), 1);
   endtask

   task automatic compare_log(input string name);
      check({name, "_count"}, log_q.size(), exp_q.size());
      for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
         check($sformatf("%s_grant%0d", name, k), log_q[k].g, exp_q[k].g);
         check($sformatf("%s_data%0d", name, k), int'(log_q[k].d), int'(exp_q[k].d));
      end
      log_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         rq[i].delete();
         ack_cnt[i] = 0;
      end
      copy_never = 1'b0;
      force_busy = 1'b0;
      busy_left  = 0;
      wait_cnt   = 0;
      bus.tx_data_copied = 1'b0;
      bus.tx_busy = 1'b0;
      drive_req();
      step();
      step();
      rst = 1'b0;
      log_q.delete();
      err_cnt   = 0;
      model_ptr = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, m, acks_before;
      bit seen;

      tbl[0] = mkvec(4'b1101, 3, 0, 2, 3, 0);
      tbl[1] = mkvec(4'b0110, 2, 1, 2, 0, 0);
      tbl[2] = mkvec(4'b0011, 2, 0, 1, 0, 0);
      tbl[3] = mkvec(4'b1001, 2, 3, 0, 0, 0);
      tbl[4] = mkvec(4'b0001, 1, 0, 0, 0, 0);
      tbl[5] = mkvec(4'b1111, 4, 1, 2, 3, 0);

      copy_dly = 0;
      busy_len = 0;
      do_reset();
      rst = 1'b1;
      step();
      check("reset_outputs", int'({bus.grant, bus.req_ack, bus.tx_transaction, bus.tx_data,
                                   bus.tx_data_ready, bus.arb_busy, bus.err_timeout}), 0);
      rst = 1'b0;

      // Single byte with exact setup and hold timing
      copy_dly = 3;
      busy_len = 8;
      rq[1].push_back(8'h41);
      drive_req();
      check("single_txn_before", int'(bus.tx_transaction), 0);
      step();
      check("single_txn_rise", int'(bus.tx_transaction), 1);
      check("single_grant", int'(bus.grant), 4'b0010);
      check("single_arb_busy", int'(bus.arb_busy), 1);
      n = 0;
      while (!bus.tx_data_ready && n < 100) begin
         step();
         n++;
      end
      check("single_setup_len", n, SETUP + 1);
      check("single_tx_data", int'(bus.tx_data), 8'h41);
      n = 0;
      seen = 1'b0;
      do begin
         step();
         n++;
         if (bus.tx_busy) seen = 1'b1;
      end while (!(seen && !bus.tx_busy) && n < 200);
      m = 0;
      while (bus.tx_transaction && m < 100) begin
         step();
         m++;
      end
      check("single_hold_len", m, HOLD);
      check("single_grant_idle", int'(bus.grant), 0);
      check("single_ack_once", ack_cnt[1], 1);
      check("single_copied_bytes", log_q.size(), 1);
      log_q.delete();

      // Table: one byte per masked requester; pointer carries between rows
      do_reset();
      copy_dly = 1;
      busy_len = 4;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            if (tbl[e].mask[i]) rq[i].push_back(8'(128 + 16 * e + i));
         end
         drive_req();
         run_drain($sformatf("tbl%0d", e), 2000);
         check($sformatf("tbl%0d_count", e), log_q.size(), tbl[e].n);
         for (int k = 0; k < tbl[e].n && k < log_q.size(); k++) begin
            check($sformatf("tbl%0d_grant%0d", e, k), log_q[k].g, int'(tbl[e].order[k]));
            check($sformatf("tbl%0d_data%0d", e, k), int'(log_q[k].d),
                  128 + 16 * e + int'(tbl[e].order[k]));
         end
         log_q.delete();
      end

      // Burst limit: six bytes on req 0 interleaved with one byte on req 1
      do_reset();
      copy_dly = 2;
      busy_len = 6;
      for (int b = 0; b < 6; b++) rq[0].push_back(8'(8'h10 + b));
      rq[1].push_back(8'h77);
      drive_req();
      build_expect();
      run_drain("burst", 3000);
      check("burst_rotate", (log_q.size() > 4) ? log_q[4].g : -1, 1);
      check("burst_resume", (log_q.size() > 5) ? int'(log_q[5].d) : -1, 8'h14);
      compare_log("burst");

      // Busy gating in WAIT_FREE
      force_busy = 1'b1;
      rq[2].push_back(8'hB2);
      drive_req();
      build_expect();
      n = 0;
      for (int c = 0; c < SETUP + 2 + 50; c++) begin
         step();
         if (bus.tx_data_ready) n++;
      end
      check("busy_gate_ready_low", n, 0);
      force_busy  = 1'b0;
      bus.tx_busy = 1'b0;
      step();
      check("busy_gate_ready_rise", int'(bus.tx_data_ready), 1);
      run_drain("busy_gate", 1000);
      compare_log("busy_gate");

      // Copy timeout on req 1
      err_cnt = 0;
      acks_before = ack_cnt[1];
      copy_never = 1'b1;
      rq[1].push_back(8'hC1);
      drive_req();
      n = 0;
      while (!bus.tx_data_ready && n < 200) begin
         step();
         n++;
      end
      n = 0;
      while (!bus.err_timeout && n < 400) begin
         step();
         n++;
      end
      check("timeout_len", n, TMO);
      check("timeout_ready_low", int'(bus.tx_data_ready), 0);
      rq[1].delete();
      drive_req();
      copy_never = 1'b0;
      m = 0;
      while (bus.tx_transaction && m < 100) begin
         step();
         m++;
      end
      check("timeout_hold_len", m, HOLD);
      check("timeout_no_ack", ack_cnt[1] - acks_before, 0);
      check("timeout_err_once", err_cnt, 1);
      model_ptr = 2;
      rq[0].push_back(8'hD0);
      rq[2].push_back(8'hD2);
      drive_req();
      build_expect();
      run_drain("after_timeout", 1000);
      compare_log("after_timeout");

      // Randomized loads checked against the queue model
      for (int it = 0; it < 8; it++) begin
         int total, acks0;
         total = 0;
         acks0 = 0;
         for (int i = 0; i < N; i++) acks0 += ack_cnt[i];
         for (int i = 0; i < N; i++) begin
            int cnt = $urandom_range(0, 6);
            for (int b = 0; b < cnt; b++) rq[i].push_back(8'($urandom));
            total += cnt;
         end
         if (total == 0) begin
            rq[it % N].push_back(8'($urandom));
            total = 1;
         end
         copy_dly = $urandom_range(0, 4);
         busy_len = $urandom_range(0, 15);
         drive_req();
         build_expect();
         run_drain($sformatf("rand%0d", it), 4000);
         for (int i = 0; i < N; i++) acks0 -= ack_cnt[i];
         check($sformatf("rand%0d_acks", it), -acks0, total);
         compare_log($sformatf("rand%0d", it));
      end

      // Reset during LOAD, then rearbitration from pointer 0
      copy_never = 1'b1;
      rq[2].push_back(8'hE2);
      drive_req();
      n = 0;
      while (!bus.tx_data_ready && n < 200) begin
         step();
         n++;
      end
      check("rst_mid_ready_seen", int'(bus.tx_data_ready), 1);
      rst = 1'b1;
      #1;
      check("rst_mid_outputs", int'({bus.grant, bus.req_ack, bus.tx_transaction,
                                     bus.tx_data_ready, bus.arb_busy}), 0);
      copy_never = 1'b0;
      busy_left  = 0;
      rq[0].push_back(8'hE0);
      drive_req();
      step();
      rst = 1'b0;
      log_q.delete();
      model_ptr = 0;
      build_expect();
      run_drain("rst_mid", 1000);
      compare_log("rst_mid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
